// File: rtl/uart_axil_pkg.sv
// Shared definitions for the axils UART register map and the poller FSM.
package uart_axil_pkg;

  // Register offsets inside the axils UART slave.
  localparam logic [31:0] REG_BAUD   = 32'h0;
  localparam logic [31:0] REG_STATUS = 32'h4;
  localparam logic [31:0] REG_RXDATA = 32'h8;

  // Status register bit positions.
  localparam int STAT_DATA_READY = 0;
  localparam int STAT_OVERRUN    = 1;

  // AXI response encoding treated as success.
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_INIT_WR,
    ST_INIT_B,
    ST_WAIT,
    ST_RD_STAT,
    ST_STAT_R,
    ST_RD_DATA,
    ST_DATA_R
  } poller_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; push and pop may coincide in any
// fill state (a push into a full FIFO is accepted when a pop frees a slot).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rptr[AW-1:0]];

  // Pointer update; reset discards contents.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write; no reset needed since empty flag guards the output.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_rx_poller.sv
// AXI-Lite master that programs the axils UART baud rate, polls its status
// register and forwards received bytes to an AXI-Stream output via a FIFO.
module uart_rx_poller
  import uart_axil_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH         = 8,
  parameter int BAUD_DEFAULT       = 9600,
  parameter int POLL_INTERVAL      = 16,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic [31:0]                     cfg_baud,
  input  logic                            cfg_baud_wr,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  output logic [DATA_WIDTH-1:0]           M_AXIS_TDATA,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic                            overrun_seen,
  output logic                            err_resp,
  output logic                            busy
);

  localparam int CNT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam int LAST  = (POLL_INTERVAL == 0) ? 0 : POLL_INTERVAL - 1;

  poller_state_t                   r_state;
  logic [CNT_W-1:0]                r_cnt;
  logic [31:0]                     r_baud;
  logic                            r_pending;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_araddr;
  logic                            r_awvalid;
  logic                            r_wvalid;
  logic                            r_bready;
  logic                            r_arvalid;
  logic                            r_rready;
  logic                            r_overrun;
  logic                            r_err;

  logic                            w_r_hs;
  logic                            w_r_ok;
  logic                            w_push;
  logic                            w_pop;
  logic                            w_full;
  logic                            w_empty;
  logic                            w_unused_rdata;

  assign w_r_hs = M_AXI_RVALID && r_rready;
  assign w_r_ok = (M_AXI_RRESP == RESP_OKAY);
  assign w_push = (r_state == ST_DATA_R) && w_r_hs && w_r_ok;
  assign w_pop  = M_AXIS_TVALID && M_AXIS_TREADY;

  // Only the low status bits and the byte lane are meaningful.
  assign w_unused_rdata = ^M_AXI_RDATA;

  assign M_AXI_AWADDR  = C_M_AXI_ADDR_WIDTH'(REG_BAUD);
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;
  assign M_AXIS_TVALID = !w_empty;
  assign overrun_seen  = r_overrun;
  assign err_resp      = r_err;
  assign busy          = (r_state != ST_WAIT);

  // Poller FSM: baud write, interval wait, status poll, data drain.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state   <= ST_INIT_WR;
      r_cnt     <= '0;
      r_baud    <= 32'(BAUD_DEFAULT);
      r_pending <= 1'b0;
      r_wdata   <= C_M_AXI_DATA_WIDTH'(BAUD_DEFAULT);
      r_araddr  <= C_M_AXI_ADDR_WIDTH'(REG_STATUS);
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_overrun <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (r_state != ST_WAIT) r_cnt <= '0;
      case (r_state)
        ST_INIT_WR: begin
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
          r_bready  <= 1'b1;
          r_state   <= ST_INIT_B;
        end
        ST_INIT_B: begin
          if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (r_wvalid && M_AXI_WREADY)   r_wvalid  <= 1'b0;
          if (M_AXI_BVALID && r_bready) begin
            r_bready <= 1'b0;
            if (M_AXI_BRESP != RESP_OKAY) r_err <= 1'b1;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == CNT_W'(LAST)) begin
            r_cnt <= '0;
            if (r_pending) begin
              // Snapshot here so WDATA stays fixed even if a new request lands.
              r_wdata   <= C_M_AXI_DATA_WIDTH'(r_baud);
              r_pending <= 1'b0;
              r_state   <= ST_INIT_WR;
            end else begin
              r_state <= ST_RD_STAT;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RD_STAT: begin
          r_araddr  <= C_M_AXI_ADDR_WIDTH'(REG_STATUS);
          r_arvalid <= 1'b1;
          r_rready  <= 1'b1;
          r_state   <= ST_STAT_R;
        end
        ST_STAT_R: begin
          if (r_arvalid && M_AXI_ARREADY) r_arvalid <= 1'b0;
          if (w_r_hs) begin
            r_rready <= 1'b0;
            if (!w_r_ok) begin
              r_err   <= 1'b1;
              r_state <= ST_WAIT;
            end else begin
              if (M_AXI_RDATA[STAT_OVERRUN]) r_overrun <= 1'b1;
              // Never read a byte we could not store; the slave overruns instead.
              if (M_AXI_RDATA[STAT_DATA_READY] && !w_full) r_state <= ST_RD_DATA;
              else                                         r_state <= ST_WAIT;
            end
          end
        end
        ST_RD_DATA: begin
          r_araddr  <= C_M_AXI_ADDR_WIDTH'(REG_RXDATA);
          r_arvalid <= 1'b1;
          r_rready  <= 1'b1;
          r_state   <= ST_DATA_R;
        end
        ST_DATA_R: begin
          if (r_arvalid && M_AXI_ARREADY) r_arvalid <= 1'b0;
          if (w_r_hs) begin
            r_rready <= 1'b0;
            if (!w_r_ok) begin
              r_err   <= 1'b1;
              r_state <= ST_WAIT;
            end else begin
              r_state <= ST_RD_STAT;
            end
          end
        end
        default: r_state <= ST_INIT_WR;
      endcase
      // A new request wins over the pending-clear at WAIT expiry.
      if (cfg_baud_wr) begin
        r_baud    <= cfg_baud;
        r_pending <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (M_AXI_ACLK),
    .i_rst   (M_AXI_ARESET),
    .i_push  (w_push),
    .i_data  (M_AXI_RDATA[DATA_WIDTH-1:0]),
    .i_pop   (w_pop),
    .o_data  (M_AXIS_TDATA),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_uart_rx_poller.sv
// Directed bench for uart_rx_poller with a reactive AXI-Lite slave model and
// a transaction/byte scoreboard.
module tb_uart_rx_poller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_baud;
  logic        cfg_baud_wr;
  logic [3:0]  AWADDR;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID, WREADY;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;
  logic [3:0]  ARADDR;
  logic        ARVALID, ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID, RREADY;
  logic [7:0]  TDATA;
  logic        TVALID, TREADY;
  logic        overrun_seen, err_resp, busy;

  always #5 clk = ~clk;

  uart_rx_poller dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cfg_baud(cfg_baud), .cfg_baud_wr(cfg_baud_wr),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY),
    .M_AXIS_TDATA(TDATA), .M_AXIS_TVALID(TVALID), .M_AXIS_TREADY(TREADY),
    .overrun_seen(overrun_seen), .err_resp(err_resp), .busy(busy)
  );

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    int          cyc;
  } txn_t;
  typedef struct {
    logic [7:0] d;
    int         cyc;
  } byte_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  txn_t        obs_q[$];
  byte_t       byte_q[$];
  int          rhs8_q[$];
  logic [31:0] stat_q[$];
  logic [33:0] data_q[$];
  logic        ar_rdy;
  logic        got_aw, got_w;
  logic [3:0]  last_ar;

  // Slave: always-ready write channels, B one cycle after AW+W, R one cycle after AR.
  assign AWREADY = 1'b1;
  assign WREADY  = 1'b1;
  assign ARREADY = ar_rdy;
  assign BRESP   = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      BVALID <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0;
      RVALID <= 1'b0; RDATA <= '0; RRESP <= 2'b00;
    end else begin
      if (BVALID && BREADY) BVALID <= 1'b0;
      if ((got_aw || (AWVALID && AWREADY)) && (got_w || (WVALID && WREADY))) begin
        BVALID <= 1'b1; got_aw <= 1'b0; got_w <= 1'b0;
      end else begin
        if (AWVALID && AWREADY) got_aw <= 1'b1;
        if (WVALID && WREADY)   got_w  <= 1'b1;
      end
      if (RVALID && RREADY) RVALID <= 1'b0;
      if (ARVALID && ARREADY) begin
        RVALID <= 1'b1;
        if (ARADDR == 4'h4) begin
          RRESP <= 2'b00;
          if (stat_q.size() > 0) RDATA <= stat_q.pop_front();
          else                   RDATA <= 32'h0;
        end else if (data_q.size() > 0) begin
          {RRESP, RDATA} <= data_q.pop_front();
        end else begin
          RRESP <= 2'b00; RDATA <= 32'h0;
        end
      end
    end
  end

  // Monitor on the falling edge: a handshake seen here completes at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      last_ar <= 4'h0;
    end else begin
      if (AWVALID && AWREADY) obs_q.push_back(txn_t'{1'b1, AWADDR, WDATA, cyc});
      if (ARVALID && ARREADY) begin
        obs_q.push_back(txn_t'{1'b0, ARADDR, 32'h0, cyc});
        last_ar <= ARADDR;
      end
      if (RVALID && RREADY && last_ar == 4'h8) rhs8_q.push_back(cyc);
      if (TVALID && TREADY) byte_q.push_back(byte_t'{TDATA, cyc});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_txn(input string tag, input bit wr, input logic [3:0] addr,
                            input logic [31:0] data, output int c);
    txn_t t;
    bit   ok = 1'b0;
    t = txn_t'{1'b0, 4'h0, 32'h0, 0};
    for (int i = 0; i < 400 && !ok; i++) begin
      if (obs_q.size() > 0) begin
        t  = obs_q.pop_front();
        ok = 1'b1;
      end else begin
        @(negedge clk); #1;
      end
    end
    chk({tag, "_seen"}, 32'(ok), 32'd1);
    chk({tag, "_kind"}, 32'(t.wr), 32'(wr));
    chk({tag, "_addr"}, 32'(t.addr), 32'(addr));
    if (wr) chk({tag, "_data"}, t.data, data);
    c = t.cyc;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] d, output int c);
    byte_t b;
    bit    ok = 1'b0;
    b = byte_t'{8'h0, 0};
    for (int i = 0; i < 400 && !ok; i++) begin
      if (byte_q.size() > 0) begin
        b  = byte_q.pop_front();
        ok = 1'b1;
      end else begin
        @(negedge clk); #1;
      end
    end
    chk({tag, "_seen"}, 32'(ok), 32'd1);
    chk({tag, "_data"}, 32'(b.d), 32'(d));
    c = b.cyc;
  endtask

  task automatic get_rhs8(output int r);
    r = -1000;
    for (int i = 0; i < 400 && rhs8_q.size() == 0; i++) begin
      @(negedge clk); #1;
    end
    chk("rhs8_seen", 32'(rhs8_q.size() > 0), 32'd1);
    if (rhs8_q.size() > 0) r = rhs8_q.pop_front();
  endtask

  task automatic flush();
    obs_q.delete(); byte_q.delete(); rhs8_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, c3, r, bc, n;
    logic [3:0] exp3 [11];
    exp3 = '{4'h4, 4'h8, 4'h4, 4'h8, 4'h4, 4'h8, 4'h4, 4'h8, 4'h4, 4'h4, 4'h4};
    rst = 1'b1; ar_rdy = 1'b1; TREADY = 1'b1; cfg_baud = '0; cfg_baud_wr = 1'b0;
    repeat (3) @(posedge clk);

    // Reset values.
    @(negedge clk);
    chk("rst_awvalid", 32'(AWVALID), 32'd0);
    chk("rst_wvalid",  32'(WVALID),  32'd0);
    chk("rst_arvalid", 32'(ARVALID), 32'd0);
    chk("rst_bready",  32'(BREADY),  32'd0);
    chk("rst_rready",  32'(RREADY),  32'd0);
    chk("rst_tvalid",  32'(TVALID),  32'd0);
    chk("rst_overrun", 32'(overrun_seen), 32'd0);
    chk("rst_err",     32'(err_resp), 32'd0);
    chk("rst_busy",    32'(busy), 32'd1);

    // Default baud write immediately after reset release, then 16-cycle WAIT.
    rst = 1'b0;
    @(negedge clk);
    chk("first_awvalid", 32'(AWVALID), 32'd1);
    chk("first_wvalid",  32'(WVALID),  32'd1);
    chk("wstrb",         32'(WSTRB),   32'hF);
    expect_txn("init_wr", 1'b1, 4'h0, 32'd9600, c1);
    for (int i = 0; i < 100 && busy !== 1'b0; i++) @(negedge clk);
    n = 0;
    while (busy === 1'b0 && n < 100) begin n++; @(negedge clk); end
    chk("wait_len", 32'(n), 32'd16);
    expect_txn("poll0", 1'b0, 4'h4, 32'h0, c1);

    // One byte available: data read, stream output, immediate re-poll.
    @(posedge clk); #1;
    flush();
    stat_q.push_back(32'h1);
    data_q.push_back({2'b00, 32'h5A});
    expect_txn("p2_stat", 1'b0, 4'h4, 32'h0, c1);
    expect_txn("p2_data", 1'b0, 4'h8, 32'h0, c2);
    expect_txn("p2_repoll", 1'b0, 4'h4, 32'h0, c3);
    get_rhs8(r);
    chk("p2_repoll_gap", 32'(c3 - r), 32'd2);
    expect_byte("p2_byte", 8'h5A, bc);
    chk("p2_byte_lat", 32'(bc - r), 32'd1);

    // Back-pressure: four bytes fill the FIFO, no further data reads.
    @(posedge clk); #1;
    TREADY = 1'b0;
    flush();
    stat_q.push_back(32'h1); stat_q.push_back(32'h1);
    stat_q.push_back(32'h1); stat_q.push_back(32'h1);
    stat_q.push_back(32'h3); stat_q.push_back(32'h1);
    data_q.push_back({2'b00, 32'hA1}); data_q.push_back({2'b00, 32'hA2});
    data_q.push_back({2'b00, 32'hA3}); data_q.push_back({2'b00, 32'hA4});
    for (int i = 0; i < 11; i++) expect_txn($sformatf("p3_t%0d", i), 1'b0, exp3[i], 32'h0, c1);
    chk("p3_overrun", 32'(overrun_seen), 32'd1);
    chk("p3_tvalid",  32'(TVALID), 32'd1);
    chk("p3_tdata",   32'(TDATA), 32'hA1);
    repeat (5) @(negedge clk);
    chk("p3_tdata_hold", 32'(TDATA), 32'hA1);
    chk("p3_no_pop", 32'(byte_q.size()), 32'd0);
    @(posedge clk); #1;
    TREADY = 1'b1;
    expect_byte("p3_b0", 8'hA1, bc);
    expect_byte("p3_b1", 8'hA2, bc);
    expect_byte("p3_b2", 8'hA3, bc);
    expect_byte("p3_b3", 8'hA4, bc);
    @(negedge clk);
    chk("p3_drained", 32'(TVALID), 32'd0);

    // Baud request during STAT_R is serviced at the next WAIT expiry.
    @(posedge clk); #1;
    flush();
    for (int i = 0; i < 100 && ARVALID !== 1'b1; i++) @(negedge clk);
    cfg_baud = 32'd115200; cfg_baud_wr = 1'b1;
    @(negedge clk);
    cfg_baud_wr = 1'b0;
    expect_txn("p4_stat", 1'b0, 4'h4, 32'h0, c1);
    expect_txn("p4_wr", 1'b1, 4'h0, 32'd115200, c2);
    expect_txn("p4_stat2", 1'b0, 4'h4, 32'h0, c3);

    // Error response on the data read: sticky error, no push, back to WAIT.
    @(posedge clk); #1;
    flush();
    chk("p5_err_before", 32'(err_resp), 32'd0);
    stat_q.push_back(32'h1);
    data_q.push_back({2'b10, 32'h77});
    expect_txn("p5_stat", 1'b0, 4'h4, 32'h0, c1);
    expect_txn("p5_data", 1'b0, 4'h8, 32'h0, c2);
    expect_txn("p5_stat2", 1'b0, 4'h4, 32'h0, c3);
    get_rhs8(r);
    chk("p5_gap", 32'(c3 - r), 32'd18);
    chk("p5_err", 32'(err_resp), 32'd1);
    chk("p5_no_byte", 32'(byte_q.size()), 32'd0);
    chk("p5_tvalid", 32'(TVALID), 32'd0);

    // Reset while an AR is stalled.
    @(posedge clk); #1;
    ar_rdy = 1'b0;
    flush();
    for (int i = 0; i < 100 && ARVALID !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    chk("p6_ar_hold", 32'(ARVALID), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("p6_rst_arvalid", 32'(ARVALID), 32'd0);
    chk("p6_rst_rready",  32'(RREADY),  32'd0);
    chk("p6_rst_busy",    32'(busy),    32'd1);
    stat_q.delete(); data_q.delete();
    rst = 1'b0; ar_rdy = 1'b1;
    flush();
    chk("p6_overrun_clr", 32'(overrun_seen), 32'd0);
    chk("p6_err_clr",     32'(err_resp),     32'd0);
    expect_txn("p6_wr", 1'b1, 4'h0, 32'd9600, c1);
    expect_txn("p6_stat", 1'b0, 4'h4, 32'h0, c2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
